// File: rtl/id_scoreboard.sv
// Register-hazard scoreboard and issue controller between decode and the ds->ex register.
// Optional feature: define SCOREBOARD_WB_BYPASS_EN to release hazards in the writeback cycle.
module id_scoreboard #(
  parameter int CNT_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ds_valid,
  input  logic [4:0]  ds_rs1,
  input  logic [4:0]  ds_rs2,
  input  logic        ds_use_rs1,
  input  logic        ds_use_rs2,
  input  logic [4:0]  ds_rd,
  input  logic        ds_rd_we,
  input  logic        ds_ex_reg_allow_in,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  output logic        ds_stall,
  output logic        ds_issue,
  output logic [31:0] busy,
  output logic [31:0] stall_cnt,
  output logic        sb_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q [32];
  logic [CNT_W-1:0] cnt_d [32];
  logic [31:0]      stall_cnt_q, stall_cnt_d;
  logic             sb_err_q, sb_err_d;

  logic rs1_busy, rs2_busy, rd_full, hazard;
  logic inc, dec;

  always_comb begin
    rs1_busy = ds_use_rs1 && (ds_rs1 != 5'd0) && (cnt_q[ds_rs1] != '0);
    rs2_busy = ds_use_rs2 && (ds_rs2 != 5'd0) && (cnt_q[ds_rs2] != '0);
    rd_full  = ds_rd_we && (ds_rd != 5'd0) && (cnt_q[ds_rd] == CNT_MAX);
`ifdef SCOREBOARD_WB_BYPASS_EN
    // The register file writes through, so the last pending write retiring this cycle releases readers.
    if (wb_we && (wb_rd == ds_rs1) && (cnt_q[ds_rs1] == CNT_ONE)) rs1_busy = 1'b0;
    if (wb_we && (wb_rd == ds_rs2) && (cnt_q[ds_rs2] == CNT_ONE)) rs2_busy = 1'b0;
    if (wb_we && (wb_rd == ds_rd)) rd_full = 1'b0;
`endif
    hazard   = rs1_busy || rs2_busy || rd_full;
    ds_stall = ds_valid && hazard;
    ds_issue = ds_valid && !hazard && ds_ex_reg_allow_in;
  end

  always_comb begin
    cnt_d[0] = '0;
    sb_err_d = sb_err_q;
    inc      = 1'b0;
    dec      = 1'b0;
    for (int r = 1; r < 32; r++) begin
      inc      = ds_issue && ds_rd_we && (ds_rd == r[4:0]);
      dec      = wb_we && (wb_rd == r[4:0]);
      cnt_d[r] = cnt_q[r];
      if (inc && !dec) begin
        cnt_d[r] = cnt_q[r] + CNT_ONE;
      end else if (dec && !inc) begin
        if (cnt_q[r] != '0) cnt_d[r] = cnt_q[r] - CNT_ONE;
        else                sb_err_d = 1'b1;
      end
    end
    stall_cnt_d = stall_cnt_q + {31'd0, ds_stall};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < 32; r++) cnt_q[r] <= '0;
      stall_cnt_q <= '0;
      sb_err_q    <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      sb_err_q    <= sb_err_d;
    end
  end

  always_comb begin
    busy = '0;
    for (int r = 1; r < 32; r++) busy[r] = (cnt_q[r] != '0);
  end

  assign stall_cnt = stall_cnt_q;
  assign sb_err    = sb_err_q;

endmodule

// File: tb/tb_id_scoreboard.sv
// Self-checking bench for id_scoreboard: directed scenarios plus randomized traffic vs. a counting model.
module tb_id_scoreboard;

  localparam int CNT_W = 2;
  localparam int MAXC  = (1 << CNT_W) - 1;
`ifdef SCOREBOARD_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        ds_valid, ds_use_rs1, ds_use_rs2, ds_rd_we, ds_ex_reg_allow_in, wb_we;
  logic [4:0]  ds_rs1, ds_rs2, ds_rd, wb_rd;
  logic        ds_stall, ds_issue, sb_err;
  logic [31:0] busy, stall_cnt;

  int          n_checks = 0;
  int          n_pass   = 0;

  int          m_cnt [32];
  bit          m_err;
  logic [31:0] m_stall;

  id_scoreboard #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .ds_valid(ds_valid), .ds_rs1(ds_rs1), .ds_rs2(ds_rs2),
    .ds_use_rs1(ds_use_rs1), .ds_use_rs2(ds_use_rs2), .ds_rd(ds_rd), .ds_rd_we(ds_rd_we),
    .ds_ex_reg_allow_in(ds_ex_reg_allow_in), .wb_we(wb_we), .wb_rd(wb_rd),
    .ds_stall(ds_stall), .ds_issue(ds_issue), .busy(busy), .stall_cnt(stall_cnt), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  function automatic bit m_src_busy(input logic [4:0] r);
    if (r == 5'd0 || m_cnt[r] == 0) return 1'b0;
    if (BYP && wb_we && wb_rd == r && m_cnt[r] == 1) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_hazard();
    bit full;
    full = ds_rd_we && ds_rd != 5'd0 && m_cnt[ds_rd] == MAXC && !(BYP && wb_we && wb_rd == ds_rd);
    return (ds_use_rs1 && m_src_busy(ds_rs1)) || (ds_use_rs2 && m_src_busy(ds_rs2)) || full;
  endfunction

  function automatic logic [31:0] m_busy();
    logic [31:0] b = '0;
    for (int r = 1; r < 32; r++) b[r] = (m_cnt[r] != 0);
    return b;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    m_err   = 1'b0;
    m_stall = '0;
  endtask

  // Advance one clock and apply the counting rules to the model using the inputs held before the edge.
  task automatic tick();
    bit e_stall, e_issue, inc, dec;
    e_stall = ds_valid && m_hazard();
    e_issue = ds_valid && !m_hazard() && ds_ex_reg_allow_in;
    @(posedge clk);
    for (int r = 1; r < 32; r++) begin
      inc = e_issue && ds_rd_we && ds_rd == 5'(r);
      dec = wb_we && wb_rd == 5'(r);
      if (inc && !dec) m_cnt[r]++;
      else if (dec && !inc) begin
        if (m_cnt[r] > 0) m_cnt[r]--;
        else m_err = 1'b1;
      end
    end
    m_stall = m_stall + 32'(e_stall);
    #1;
  endtask

  task automatic idle_inputs();
    ds_valid = 0; ds_use_rs1 = 0; ds_use_rs2 = 0; ds_rd_we = 0; ds_ex_reg_allow_in = 1;
    wb_we = 0; ds_rs1 = 0; ds_rs2 = 0; ds_rd = 0; wb_rd = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    n_checks++; if (busy !== 32'd0) $display("FAIL reset_busy got=%h want=0", busy); else n_pass++;
    n_checks++; if (stall_cnt !== 32'd0) $display("FAIL reset_stall_cnt got=%0d want=0", stall_cnt); else n_pass++;
    n_checks++; if (sb_err !== 1'b0) $display("FAIL reset_sb_err got=%b want=0", sb_err); else n_pass++;
    n_checks++; if ({ds_stall, ds_issue} !== 2'b00) $display("FAIL reset_stall_issue got=%b want=00", {ds_stall, ds_issue}); else n_pass++;
  endtask

  task automatic test_raw();
    ds_valid = 1; ds_rd = 5; ds_rd_we = 1; #1;
    n_checks++; if (ds_issue !== 1'b1) $display("FAIL raw_issue_rd5 got=%b want=1", ds_issue); else n_pass++;
    tick();
    ds_rd_we = 0; ds_use_rs1 = 1; ds_rs1 = 5; #1;
    n_checks++; if (ds_stall !== 1'b1) $display("FAIL raw_stall got=%b want=1", ds_stall); else n_pass++;
    n_checks++; if (busy[5] !== 1'b1) $display("FAIL raw_busy5 got=%b want=1", busy[5]); else n_pass++;
    wb_we = 1; wb_rd = 5; #1;
    n_checks++; if (ds_stall !== !BYP) $display("FAIL raw_wb_cycle_stall got=%b want=%b", ds_stall, !BYP); else n_pass++;
    tick();
    wb_we = 0; #1;
    n_checks++; if ({ds_stall, ds_issue} !== 2'b01) $display("FAIL raw_release got=%b want=01", {ds_stall, ds_issue}); else n_pass++;
    n_checks++; if (busy[5] !== 1'b0) $display("FAIL raw_busy5_clear got=%b want=0", busy[5]); else n_pass++;
    tick();
    idle_inputs(); #1;
  endtask

  task automatic test_x0();
    ds_valid = 1; ds_rd = 0; ds_rd_we = 1; #1;
    n_checks++; if (ds_issue !== 1'b1) $display("FAIL x0_issue got=%b want=1", ds_issue); else n_pass++;
    tick();
    ds_rd_we = 0; ds_use_rs1 = 1; ds_rs1 = 0; #1;
    n_checks++; if (ds_stall !== 1'b0) $display("FAIL x0_stall got=%b want=0", ds_stall); else n_pass++;
    n_checks++; if (busy !== 32'd0) $display("FAIL x0_busy got=%h want=0", busy); else n_pass++;
    idle_inputs(); wb_we = 1; wb_rd = 0;
    tick();
    idle_inputs(); #1;
    n_checks++; if (sb_err !== 1'b0) $display("FAIL x0_sb_err got=%b want=0", sb_err); else n_pass++;
  endtask

  task automatic test_full();
    ds_valid = 1; ds_rd = 7; ds_rd_we = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (ds_issue !== 1'b1) $display("FAIL full_issue%0d got=%b want=1", i, ds_issue); else n_pass++;
      tick();
    end
    #1;
    n_checks++; if (ds_stall !== 1'b1) $display("FAIL full_fourth_stall got=%b want=1", ds_stall); else n_pass++;
    tick();
    wb_we = 1; wb_rd = 7; #1;
    if (BYP) begin
      n_checks++; if (ds_issue !== 1'b1) $display("FAIL full_bypass_issue got=%b want=1", ds_issue); else n_pass++;
      tick();
    end else begin
      n_checks++; if (ds_stall !== 1'b1) $display("FAIL full_wb_cycle_stall got=%b want=1", ds_stall); else n_pass++;
      tick();
      wb_we = 0; #1;
      n_checks++; if (ds_issue !== 1'b1) $display("FAIL full_fourth_issue got=%b want=1", ds_issue); else n_pass++;
      tick();
    end
    wb_we = 0; #1;
    n_checks++; if (ds_stall !== 1'b1) $display("FAIL full_cnt3_again got=%b want=1", ds_stall); else n_pass++;
    idle_inputs(); wb_we = 1; wb_rd = 7;
    repeat (3) tick();
    idle_inputs(); #1;
    n_checks++; if (busy[7] !== 1'b0) $display("FAIL full_drain_busy7 got=%b want=0", busy[7]); else n_pass++;
    n_checks++; if (sb_err !== 1'b0) $display("FAIL full_drain_sb_err got=%b want=0", sb_err); else n_pass++;
  endtask

  task automatic test_same_cycle();
    ds_valid = 1; ds_rd = 3; ds_rd_we = 1;
    tick();
    wb_we = 1; wb_rd = 3; #1;
    n_checks++; if (ds_issue !== 1'b1) $display("FAIL same_issue got=%b want=1", ds_issue); else n_pass++;
    tick();
    idle_inputs(); #1;
    n_checks++; if (busy[3] !== 1'b1) $display("FAIL same_busy3 got=%b want=1", busy[3]); else n_pass++;
    wb_we = 1; wb_rd = 3;
    tick();
    idle_inputs(); #1;
    n_checks++; if (busy[3] !== 1'b0) $display("FAIL same_busy3_after_wb got=%b want=0", busy[3]); else n_pass++;
  endtask

  task automatic test_err_and_async_reset();
    wb_we = 1; wb_rd = 9;
    tick();
    idle_inputs();
    repeat (3) tick();
    n_checks++; if (sb_err !== 1'b1) $display("FAIL err_sticky got=%b want=1", sb_err); else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_checks++; if ({sb_err, busy, stall_cnt} !== 65'd0) $display("FAIL async_reset got err=%b busy=%h stall=%0d want 0", sb_err, busy, stall_cnt); else n_pass++;
    model_reset();
    #2 reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_stall_count();
    ds_valid = 1; ds_rd = 10; ds_rd_we = 1;
    tick();
    ds_rd_we = 0; ds_use_rs1 = 1; ds_rs1 = 10;
    repeat (10) tick();
    n_checks++; if (stall_cnt !== 32'd10) $display("FAIL stall_cnt_10 got=%0d want=10", stall_cnt); else n_pass++;
    idle_inputs(); wb_we = 1; wb_rd = 10;
    tick();
    idle_inputs(); ds_valid = 1; ds_ex_reg_allow_in = 0; ds_use_rs1 = 1; ds_rs1 = 10; ds_rd = 11; ds_rd_we = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++; if ({ds_stall, ds_issue} !== 2'b00) $display("FAIL backpressure_%0d got=%b want=00", i, {ds_stall, ds_issue}); else n_pass++;
      tick();
    end
    n_checks++; if (stall_cnt !== 32'd10) $display("FAIL backpressure_stall_cnt got=%0d want=10", stall_cnt); else n_pass++;
    n_checks++; if (busy[11] !== 1'b0) $display("FAIL backpressure_no_issue got=%b want=0", busy[11]); else n_pass++;
    idle_inputs(); #1;
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 400; i++) begin
      ds_valid           = ($urandom_range(0, 3) != 0);
      ds_rs1             = 5'($urandom_range(0, 7));
      ds_rs2             = 5'($urandom_range(0, 7));
      ds_use_rs1         = $urandom_range(0, 1) == 1;
      ds_use_rs2         = $urandom_range(0, 1) == 1;
      ds_rd              = 5'($urandom_range(0, 7));
      ds_rd_we           = $urandom_range(0, 2) != 0;
      ds_ex_reg_allow_in = $urandom_range(0, 4) != 0;
      r                  = $urandom_range(0, 7);
      wb_rd              = 5'(r);
      wb_we              = (m_cnt[r] > 0 && $urandom_range(0, 1) == 1) || ($urandom_range(0, 60) == 0);
      #1;
      n_checks++; if (ds_stall !== (ds_valid && m_hazard())) $display("FAIL rnd_stall cyc=%0d got=%b want=%b", i, ds_stall, ds_valid && m_hazard()); else n_pass++;
      n_checks++; if (ds_issue !== (ds_valid && !m_hazard() && ds_ex_reg_allow_in)) $display("FAIL rnd_issue cyc=%0d got=%b want=%b", i, ds_issue, ds_valid && !m_hazard() && ds_ex_reg_allow_in); else n_pass++;
      tick();
      n_checks++; if (busy !== m_busy()) $display("FAIL rnd_busy cyc=%0d got=%h want=%h", i, busy, m_busy()); else n_pass++;
      n_checks++; if (stall_cnt !== m_stall) $display("FAIL rnd_stall_cnt cyc=%0d got=%0d want=%0d", i, stall_cnt, m_stall); else n_pass++;
      n_checks++; if (sb_err !== m_err) $display("FAIL rnd_sb_err cyc=%0d got=%b want=%b", i, sb_err, m_err); else n_pass++;
    end
    idle_inputs(); #1;
  endtask

  initial begin
    test_reset();
    test_raw();
    test_x0();
    test_full();
    test_same_cycle();
    test_err_and_async_reset();
    test_stall_count();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
